// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, and the alignment/size legality check.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // True for the reserved size and for halves/words not naturally aligned.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: picks and extends the addressed byte/half of a read word for loads,
// and splices store data into the addressed lane of a read word for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    load_data_o = rdata_i;
    case (size_i)
      SIZE_BYTE: load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default:   load_data_o = rdata_i;
    endcase
  end

  // Untouched lanes come straight from the read word so they survive bit-exactly.
  always_comb begin
    merge_data_o = rdata_i;
    case (size_i)
      SIZE_BYTE: begin
        case (addr_lo_i)
          2'd0:    merge_data_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_data_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_data_o[23:16] = wdata_i[7:0];
          default: merge_data_o[31:24] = wdata_i[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (addr_lo_i[1]) merge_data_o[31:16] = wdata_i[15:0];
        else              merge_data_o[15:0]  = wdata_i[15:0];
      end
      default: merge_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request in flight; load/SW 2 cycles, SB/SH 3 (read-modify-write), fault 1.
// reqReady only in IDLE. Optional LSU_BOUNDS_CHECK_EN adds an out-of-range fault against MEM_BYTES.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        rspValid,
  output logic [31:0] rspData,
  output logic        rspFault,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  lsu_state_e  state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic [31:0] rsp_data_q;
  logic        rsp_fault_q;
  logic [31:0] address_q;
  logic [31:0] write_data_q;

  logic        req_fault;
  logic [31:0] load_data;
  logic [31:0] merge_data;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
  assign req_fault = is_bad_access(reqSize, reqAddr[1:0]) ||
                     ({reqAddr[31:2], 2'b00} > LAST_WORD);
`else
  assign req_fault = is_bad_access(reqSize, reqAddr[1:0]);
`endif

  lsu_align u_align (
    .size_i       (size_q),
    .unsigned_i   (unsigned_q),
    .addr_lo_i    (addr_lo_q),
    .rdata_i      (readData),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= SIZE_BYTE;
      unsigned_q   <= 1'b0;
      addr_lo_q    <= 2'b00;
      wdata_q      <= 32'h0;
      rsp_data_q   <= 32'h0;
      rsp_fault_q  <= 1'b0;
      address_q    <= 32'h0;
      write_data_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reqValid) begin
            write_q     <= reqWrite;
            size_q      <= reqSize;
            unsigned_q  <= reqUnsigned;
            addr_lo_q   <= reqAddr[1:0];
            wdata_q     <= reqWData;
            rsp_data_q  <= 32'h0;
            rsp_fault_q <= req_fault;
            if (req_fault) begin
              state_q <= RESP;
            end else begin
              address_q <= {reqAddr[31:2], 2'b00};
              if (reqWrite && reqSize == SIZE_WORD) begin
                write_data_q <= reqWData;
                state_q      <= WRITE;
              end else begin
                state_q <= READ;
              end
            end
          end
        end
        READ: begin
          if (write_q) begin
            write_data_q <= merge_data;
            state_q      <= WRITE;
          end else begin
            rsp_data_q <= load_data;
            state_q    <= RESP;
          end
        end
        WRITE:   state_q <= RESP;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reqReady  = (state_q == IDLE);
  assign rspValid  = (state_q == RESP);
  assign rspData   = rsp_data_q;
  assign rspFault  = rsp_fault_q;
  assign MemRead   = (state_q == READ);
  // A reset landing on the WRITE cycle must not let the stale word reach memory.
  assign MemWrite  = (state_q == WRITE) && !reset;
  assign address   = address_q;
  assign writeData = write_data_q;

endmodule
